// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end controller for the stopwatch timing datapath.
// - Conditions the raw S0..S4 buttons and the SW7 mode switch. Each input goes
//   through a 2-FF synchroniser and a stability-counter debouncer. Each button
//   gives one single-cycle pulse on the rising edge of its debounced level.
// - Owns the IDLE/RUN/PAUSE/ALARM state machine, the tick divider and the
//   alarm-duration counter.
//
// Handshake/strobe semantics: there are no valid/ready pairs. Every strobe
// output (tick, clr, inc_min, inc_hour) is a single-cycle pulse that the
// datapath consumes on the next rising clk edge. Levels (run, alarm, mode,
// state) are stable between edges.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   btn_clear/start/stop/min/hour   raw buttons S0..S4, active-high
//   sw_countdown      raw SW7, 1 = count down
//   time_zero         datapath reports all digits zero
//   tick              one-cycle count strobe (RUN only)
//   clr               one-cycle synchronous clear to the datapath
//   run               high in RUN
//   mode              latched count direction (1 = down)
//   inc_min/inc_hour  one-cycle set pulses (IDLE/PAUSE, countdown mode only)
//   alarm             high in ALARM
//   state             debug view of the FSM: IDLE=0, RUN=1, PAUSE=2, ALARM=3
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 100,
    parameter int DB_CYCLES   = 2000000,
    parameter int ALARM_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_clear,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_min,
    input  logic       btn_hour,
    input  logic       sw_countdown,
    input  logic       time_zero,
    output logic       tick,
    output logic       clr,
    output logic       run,
    output logic       mode,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AL_W   = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int NUM_IN = 6;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [AL_W-1:0]  AL_LAST  = AL_W'(ALARM_TICKS - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    // Input bit positions in the conditioning vectors.
    localparam int I_CLEAR = 0;
    localparam int I_START = 1;
    localparam int I_STOP  = 2;
    localparam int I_MIN   = 3;
    localparam int I_HOUR  = 4;
    localparam int I_SW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;
    logic [NUM_IN-1:0] db_lvl;
    logic [DB_W-1:0]   db_cnt [NUM_IN];
    logic [4:0]        db_prev;   // buttons only; the switch is used as a level
    logic [4:0]        pulse;

    assign raw = {sw_countdown, btn_hour, btn_min, btn_stop, btn_start, btn_clear};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db_lvl[4:0];
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // Stable for DB_CYCLES cycles: accept the new level.
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level: one pulse per press, no repeat.
    assign pulse = db_lvl[4:0] & ~db_prev;

    logic p_clear, p_start, p_stop, p_min, p_hour;
    assign p_clear = pulse[I_CLEAR];
    assign p_start = pulse[I_START];
    assign p_stop  = pulse[I_STOP];
    assign p_min   = pulse[I_MIN];
    assign p_hour  = pulse[I_HOUR];

    // ------------------------------------------------------------------
    // FSM, divider and alarm counter
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_next;
    logic [AL_W-1:0]  al_q, al_d;
    logic             mode_q;
    logic             div_wrap;
    logic             zero_hit;
    logic             set_ok;
    logic             clr_c, inc_min_c, inc_hour_c, tick_c;

    assign div_wrap = (div_q == DIV_LAST);
    assign div_next = div_wrap ? '0 : div_q + 1'b1;

    // Countdown has reached zero: the datapath must not see another tick.
    assign zero_hit = mode_q && time_zero;

    // Set pulses only act when no higher-priority pulse is present.
    assign set_ok = mode_q && !p_clear && !p_stop && !p_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            al_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            al_q    <= al_d;
            // Direction can only change while the counter is not moving.
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                mode_q <= db_lvl[I_SW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        al_d       = al_q;
        clr_c      = 1'b0;
        inc_min_c  = 1'b0;
        inc_hour_c = 1'b0;

        // tick follows the divider whenever RUN, independent of pulses.
        tick_c = (state_q == ST_RUN) && div_wrap && !zero_hit;

        if (p_clear) begin
            clr_c   = 1'b1;
            state_d = ST_IDLE;
            div_d   = '0;
            al_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!p_stop && p_start && !zero_hit) begin
                        state_d = ST_RUN;
                    end
                    inc_min_c  = set_ok && p_min;
                    inc_hour_c = set_ok && p_hour;
                end
                ST_RUN: begin
                    // The divider advances in every RUN cycle, including the
                    // one that leaves RUN, so a pause resumes on the same phase.
                    div_d = div_next;
                    if (p_stop) begin
                        state_d = ST_PAUSE;
                    end else if (zero_hit) begin
                        state_d = ST_ALARM;
                        al_d    = '0;
                    end
                end
                ST_PAUSE: begin
                    if (!p_stop && p_start) begin
                        state_d = ST_RUN;
                    end
                    inc_min_c  = set_ok && p_min;
                    inc_hour_c = set_ok && p_hour;
                end
                ST_ALARM: begin
                    div_d = div_next;
                    if (p_start || p_stop) begin
                        // Silence: back to IDLE without clearing the datapath.
                        state_d = ST_IDLE;
                    end else if (div_wrap) begin
                        if (al_q == AL_LAST) begin
                            state_d = ST_IDLE;
                            al_d    = '0;
                        end else begin
                            al_d = al_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign tick     = tick_c;
    assign clr      = clr_c;
    assign run      = (state_q == ST_RUN);
    assign alarm    = (state_q == ST_ALARM);
    assign mode     = mode_q;
    assign inc_min  = inc_min_c;
    assign inc_hour = inc_hour_c;
    assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10),
// DB_CYCLES=4, ALARM_TICKS=3. Inputs change 1 time unit after a rising edge;
// outputs are observed on the falling edge by the monitor, and state-level
// checks are taken 1 unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DIV   = 10;
    localparam int DB    = 4;
    localparam int AL_T  = 3;

    localparam logic [1:0] EV_MIN  = 2'd1;
    localparam logic [1:0] EV_HOUR = 2'd2;
    localparam logic [1:0] EV_CLR  = 2'd3;

    localparam int B_CLEAR = 0;
    localparam int B_START = 1;
    localparam int B_STOP  = 2;
    localparam int B_MIN   = 3;
    localparam int B_HOUR  = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_clear, btn_start, btn_stop, btn_min, btn_hour;
    logic       sw_countdown;
    logic       time_zero;
    logic       tick, clr, run, mode, inc_min, inc_hour, alarm;
    logic [1:0] state;

    stopwatch_ctrl #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .DB_CYCLES   (DB),
        .ALARM_TICKS (AL_T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_clear    (btn_clear),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .btn_min      (btn_min),
        .btn_hour     (btn_hour),
        .sw_countdown (sw_countdown),
        .time_zero    (time_zero),
        .tick         (tick),
        .clr          (clr),
        .run          (run),
        .mode         (mode),
        .inc_min      (inc_min),
        .inc_hour     (inc_hour),
        .alarm        (alarm),
        .state        (state)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int min_cnt = 0;
    int hour_cnt = 0;
    int clr_cnt = 0;
    int phase_cnt = 0;
    bit model_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops expected pulse events, models the tick phase
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [1:0] code;
        if (rst_n) begin
            code = clr ? EV_CLR : (inc_hour ? EV_HOUR : (inc_min ? EV_MIN : 2'd0));
            if (inc_min)  min_cnt++;
            if (inc_hour) hour_cnt++;
            if (clr)      clr_cnt++;
            if (tick)     tick_cnt++;
            if (code != 2'd0) begin
                if (exp_q.size() == 0) check("unexpected_pulse", 32'(code), 32'd0);
                else                   check("pulse_event", 32'(code), 32'(exp_q.pop_front()));
            end
            if (state != 2'd1) begin
                check("tick_outside_run", 32'(tick), 32'd0);
            end else if (model_en) begin
                phase_cnt++;
                check("tick_phase", 32'(tick), 32'(phase_cnt == DIV));
                if (phase_cnt == DIV) phase_cnt = 0;
            end
            if (clr) phase_cnt = 0;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_CLEAR: btn_clear = v;
            B_START: btn_start = v;
            B_STOP:  btn_stop  = v;
            B_MIN:   btn_min   = v;
            default: btn_hour  = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        cyc(hold);
        set_btn(b, 1'b0);
        cyc(10);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int t0;
        int m0, h0, c0;
        int n;

        rst_n = 1'b0;
        btn_clear = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
        btn_min = 1'b0; btn_hour = 1'b0;
        sw_countdown = 1'b0; time_zero = 1'b0;

        // 1. Reset, then a long start press.
        cyc(3);
        check("reset_outputs", {25'd0, tick, clr, run, mode, inc_min, inc_hour, alarm}, 32'd0);
        check("reset_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        model_en = 1'b1;
        cyc(2);

        btn_start = 1'b1;
        lat = 0;
        while (state != 2'd1 && lat < 20) begin
            cyc(1);
            lat++;
        end
        check("start_latency_ok", 32'(lat <= DB + 3), 32'd1);
        t0 = tick_cnt;
        cyc(13);
        btn_start = 1'b0;
        cyc(37);
        check("ticks_in_50", 32'(tick_cnt - t0), 32'd5);
        check("run_after_hold", 32'(state), 32'd1);
        check("run_level", 32'(run), 32'd1);

        // 2. Stop glitch, real stop, resume.
        set_btn(B_STOP, 1'b1);
        cyc(2);
        set_btn(B_STOP, 1'b0);
        cyc(10);
        check("glitch_ignored", 32'(state), 32'd1);
        press(B_STOP, 10);
        check("paused", 32'(state), 32'd2);
        t0 = tick_cnt;
        cyc(25);
        check("no_tick_paused", 32'(tick_cnt - t0), 32'd0);
        press(B_START, 10);
        check("resumed", 32'(state), 32'd1);
        cyc(30);
        exp_q.push_back(EV_CLR);
        press(B_CLEAR, 8);
        check("clear_to_idle", 32'(state), 32'd0);

        // 3. Set pulses in countdown mode, then suppressed in RUN.
        sw_countdown = 1'b1;
        cyc(12);
        check("mode_in_idle", 32'(mode), 32'd1);
        m0 = min_cnt; h0 = hour_cnt;
        exp_q.push_back(EV_MIN);
        press(B_MIN, 8);
        exp_q.push_back(EV_MIN);
        press(B_MIN, 8);
        exp_q.push_back(EV_HOUR);
        press(B_HOUR, 12);
        check("inc_min_count", 32'(min_cnt - m0), 32'd2);
        check("inc_hour_count", 32'(hour_cnt - h0), 32'd1);
        check("set_queue_drained", 32'(exp_q.size()), 32'd0);
        press(B_START, 8);
        check("run_countdown", 32'(state), 32'd1);
        m0 = min_cnt; h0 = hour_cnt;
        press(B_MIN, 8);
        press(B_HOUR, 8);
        check("inc_min_run", 32'(min_cnt - m0), 32'd0);
        check("inc_hour_run", 32'(hour_cnt - h0), 32'd0);

        // 4. Countdown hits zero: timed alarm, then silenced alarm.
        model_en = 1'b0;
        time_zero = 1'b1;
        #1;
        check("tick_forced_low", 32'(tick), 32'd0);
        cyc(1);
        check("alarm_state", 32'(state), 32'd3);
        check("alarm_level", 32'(alarm), 32'd1);
        check("alarm_run_low", 32'(run), 32'd0);
        n = 0;
        while (state == 2'd3 && n < 40) begin
            cyc(1);
            n++;
        end
        check("alarm_len_ok", 32'(n >= (AL_T - 1) * DIV + 1 && n <= AL_T * DIV), 32'd1);
        check("alarm_timeout_idle", 32'(state), 32'd0);
        check("alarm_cleared", 32'(alarm), 32'd0);

        time_zero = 1'b0;
        press(B_START, 8);
        check("rerun", 32'(state), 32'd1);
        time_zero = 1'b1;
        cyc(1);
        check("alarm_again", 32'(state), 32'd3);
        c0 = clr_cnt;
        cyc(3);
        btn_start = 1'b1;
        n = 0;
        while (state == 2'd3 && n < 20) begin
            cyc(1);
            n++;
        end
        check("silence_idle", 32'(state), 32'd0);
        check("silence_early", 32'(4 + n < (AL_T - 1) * DIV + 1), 32'd1);
        btn_start = 1'b0;
        cyc(10);
        check("silence_no_clr", 32'(clr_cnt - c0), 32'd0);

        // 5. Start blocked at zero in countdown; mode frozen in RUN.
        press(B_START, 8);
        check("start_blocked_zero", 32'(state), 32'd0);
        time_zero = 1'b0;
        press(B_START, 8);
        check("run_mode1", 32'(state), 32'd1);
        sw_countdown = 1'b0;
        cyc(12);
        check("mode_frozen_run", 32'(mode), 32'd1);
        press(B_STOP, 8);
        check("pause_mode", 32'(state), 32'd2);
        check("mode_follows_pause", 32'(mode), 32'd0);

        // 6. Clear + stop together in RUN, then async reset mid-run.
        press(B_START, 8);
        check("run_mode0", 32'(state), 32'd1);
        c0 = clr_cnt;
        exp_q.push_back(EV_CLR);
        btn_clear = 1'b1;
        btn_stop  = 1'b1;
        cyc(10);
        btn_clear = 1'b0;
        btn_stop  = 1'b0;
        cyc(10);
        check("clear_wins", 32'(state), 32'd0);
        check("clr_once", 32'(clr_cnt - c0), 32'd1);
        press(B_START, 8);
        check("run_before_reset", 32'(state), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {23'd0, tick, clr, run, mode, inc_min, inc_hour, alarm, state}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("idle_after_reset", 32'(state), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end controller for the stopwatch timing datapath. Conditions the raw S0–S4 buttons and the SW7 mode switch, and owns the Run/Pause/Idle/Alarm state machine. Drives the datapath's count-enable strobe, clear, run level, latched mode and minute/hour set pulses. Raises a timed alarm when a countdown reaches zero. Sits between the board I/O and the counter datapath; all outputs are synchronous to clk.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
TICK_HZ, 100, count strobe rate; DIV = CLK_HZ/TICK_HZ (integer, >=2)
DB_CYCLES, 2000000, clk cycles a synchronised input must stay stable before its debounced level changes (>=2)
ALARM_TICKS, 300, alarm duration in ticks (3 s at 100 Hz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_clear  in  1  raw S0, active-high
btn_start  in  1  raw S1
btn_stop  in  1  raw S2
btn_min  in  1  raw S3
btn_hour  in  1  raw S4
sw_countdown  in  1  raw SW7 (1 = countdown)
time_zero  in  1  datapath reports hh=mm=ss=xx=0
tick  out  1  one-cycle count strobe to datapath
clr  out  1  one-cycle synchronous clear to datapath
run  out  1  level, high in RUN
mode  out  1  latched count direction (1 = down)
inc_min  out  1  one-cycle minute-increment pulse
inc_hour  out  1  one-cycle hour-increment pulse
alarm  out  1  level, high in ALARM
state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; divider, debounce and alarm counters 0; debounced levels 0. Reset mid-run aborts immediately; no clr pulse is generated.
- Input conditioning, per input:
  - 2-FF synchroniser.
  - Debounce counter: increments while the synced value differs from the debounced level; cleared when they are equal. When it reaches DB_CYCLES-1 while still differing, the debounced level flips on the next edge.
  - Button pulse: one cycle, on the rising edge of the debounced level.
  - Held button: exactly one pulse; no auto-repeat.
- mode: copies the debounced SW7 only in IDLE and PAUSE. It is frozen in RUN and ALARM.
- Pulse priority in one cycle: clear > stop > start > min/hour.
- Clear pulse:
  - From any state: clr=1 for that cycle, next state IDLE, divider := 0, alarm counter := 0.
  - A clear during ALARM also emits clr.
- IDLE:
  - start → RUN, except when mode=1 and time_zero=1 (start ignored).
  - min/hour pulses drive inc_min/inc_hour, but only if mode=1.
- RUN:
  - run=1.
  - Divider counts 0..DIV-1 and wraps. tick=1 in the cycle the divider equals DIV-1.
  - stop → PAUSE, divider held (phase preserved across pause).
  - inc_min/inc_hour are suppressed.
  - If mode=1 and time_zero=1: → ALARM on the next edge, tick forced 0 from that cycle, alarm counter := 0.
- PAUSE:
  - start → RUN.
  - Set pulses are handled as in IDLE.
  - stop is ignored.
- ALARM:
  - alarm=1, run=0, tick=0.
  - Divider keeps running; each internal wrap increments the alarm counter.
  - When the alarm counter = ALARM_TICKS-1 at a wrap → IDLE.
  - start or stop pulse → IDLE immediately (silence), no clr.
- Simultaneous start and stop → stop wins.
- A start in RUN is ignored.
- Divider width: clog2(DIV). Alarm counter width: clog2(ALARM_TICKS). All arithmetic is unsigned with wrap by compare, never by overflow.

Test Plan:
Parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DB_CYCLES=4, ALARM_TICKS=3.
1. Reset, then a btn_start pulse held 20 cycles → exactly one start pulse; state=1 within DB_CYCLES+3 cycles; tick high every 10th cycle; 5 ticks over 50 cycles.
2. A 2-cycle glitch on btn_stop while RUN → no state change. A 10-cycle press → state=2; the tick count resumes at the same divider phase after the next start.
3. sw_countdown=1 in IDLE, btn_min pressed twice, btn_hour once → inc_min pulses 2, inc_hour pulses 1, each 1 cycle wide. Same presses in RUN → no pulses.
4. mode=1, RUN, time_zero driven 1 → state=3 next edge, alarm=1, tick=0. After 30 cycles → state=0, alarm=0. Repeat with a start press mid-alarm → state=0 early, clr=0.
5. Start with time_zero=1 and mode=1 in IDLE → state stays 0. Toggle SW7 while RUN → mode unchanged until PAUSE.
6. Clear and stop pressed in the same debounced cycle while RUN → clr=1 for one cycle, state=0. rst_n pulled low mid-run → all outputs 0 asynchronously.
